// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared defines for the write-back register file
package wb_regfile_pkg;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int RegNum     = 32;

  localparam logic [RegBus-1:0]     ZeroWord   = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

endpackage

// File: rtl/wb_regfile_hilo_reg.sv
// rtl/wb_regfile_hilo_reg.sv - HI/LO register pair with write-through bypass
module hilo_reg
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = RegBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] hi_d,
  input  logic [DATA_W-1:0] lo_d,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // HI and LO load independently; reset wins over a same-edge write
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we == WriteEnable) hi_q <= hi_d;
      if (lo_we == WriteEnable) lo_q <= lo_d;
    end
  end

  // Forward the value being written this cycle so EX sees it without a stall
  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (rst != RstEnable) begin
      hi_o = (hi_we == WriteEnable) ? hi_d : hi_q;
      lo_o = (lo_we == WriteEnable) ? lo_d : lo_q;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - GPR file + HI/LO write-back sink; optional WB_REGFILE_TRACE_EN adds write trace
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W  = RegBus,
  parameter int ADDR_W  = RegAddrBus,
  parameter int REG_NUM = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic              wb_reg_we,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_hi_we,
  input  logic              wb_lo_we,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
`ifdef WB_REGFILE_TRACE_EN
  ,
  input  logic [31:0]       wb_inst,
  output logic [31:0]       dbg_last_inst,
  output logic [31:0]       dbg_gpr_wr_cnt
`endif
);

  logic [DATA_W-1:0] gpr [REG_NUM];
  logic              wr_accept;

  // $0 is hardwired: a write aimed at it is not a write at all
  assign wr_accept = (wb_reg_we == WriteEnable) && (wb_waddr != '0);

  // GPR array; reset clears every entry, including the unused $0 slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < REG_NUM; i++) gpr[i] <= '0;
    end else if (wr_accept) begin
      gpr[wb_waddr] <= wb_data;
    end
  end

  // Read port 1: reset, disable and $0 force zero, then same-cycle bypass
  always_comb begin
    rdata1 = '0;
    if (rst == RstEnable || re1 != ReadEnable || raddr1 == '0)
      rdata1 = '0;
    else if (wb_reg_we == WriteEnable && raddr1 == wb_waddr)
      rdata1 = wb_data;
    else
      rdata1 = gpr[raddr1];
  end

  // Read port 2: identical rules, fully independent of port 1
  always_comb begin
    rdata2 = '0;
    if (rst == RstEnable || re2 != ReadEnable || raddr2 == '0)
      rdata2 = '0;
    else if (wb_reg_we == WriteEnable && raddr2 == wb_waddr)
      rdata2 = wb_data;
    else
      rdata2 = gpr[raddr2];
  end

  hilo_reg #(
    .DATA_W (DATA_W)
  ) u_hilo (
    .clk   (clk),
    .rst   (rst),
    .hi_we (wb_hi_we),
    .lo_we (wb_lo_we),
    .hi_d  (wb_hi),
    .lo_d  (wb_lo),
    .hi_o  (hi_o),
    .lo_o  (lo_o)
  );

`ifdef WB_REGFILE_TRACE_EN
  // Record the instruction and count of every GPR write that actually lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      dbg_last_inst  <= '0;
      dbg_gpr_wr_cnt <= '0;
    end else if (wr_accept) begin
      dbg_last_inst  <= wb_inst;
      dbg_gpr_wr_cnt <= dbg_gpr_wr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wb_waddr;
  logic        wb_reg_we;
  logic [31:0] wb_data;
  logic        wb_hi_we;
  logic        wb_lo_we;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
`ifdef WB_REGFILE_TRACE_EN
  logic [31:0] wb_inst;
  logic [31:0] dbg_last_inst;
  logic [31:0] dbg_gpr_wr_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic run_cmp = 1'b0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .wb_waddr  (wb_waddr),
    .wb_reg_we (wb_reg_we),
    .wb_data   (wb_data),
    .wb_hi_we  (wb_hi_we),
    .wb_lo_we  (wb_lo_we),
    .wb_hi     (wb_hi),
    .wb_lo     (wb_lo),
    .re1       (re1),
    .raddr1    (raddr1),
    .rdata1    (rdata1),
    .re2       (re2),
    .raddr2    (raddr2),
    .rdata2    (rdata2),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
`ifdef WB_REGFILE_TRACE_EN
    ,
    .wb_inst        (wb_inst),
    .dbg_last_inst  (dbg_last_inst),
    .dbg_gpr_wr_cnt (dbg_gpr_wr_cnt)
`endif
  );

  // Reference model: architectural register contents
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo;
  logic [31:0] m_cnt, m_last;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_gpr[i] <= 32'h0;
      m_hi <= 32'h0; m_lo <= 32'h0; m_cnt <= 32'h0; m_last <= 32'h0;
    end else begin
      if (wb_reg_we && wb_waddr != 5'd0) begin
        m_gpr[wb_waddr] <= wb_data;
        m_cnt <= m_cnt + 32'd1;
`ifdef WB_REGFILE_TRACE_EN
        m_last <= wb_inst;
`endif
      end
      if (wb_hi_we) m_hi <= wb_hi;
      if (wb_lo_we) m_lo <= wb_lo;
    end
  end

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
    if (rst || !re || a == 5'd0) return 32'h0;
    if (wb_reg_we && a == wb_waddr) return wb_data;
    return m_gpr[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare every output against the model in the middle of each cycle
  always @(negedge clk) begin
    if (run_cmp) begin
      check("cmp_rdata1", rdata1, exp_rd(re1, raddr1));
      check("cmp_rdata2", rdata2, exp_rd(re2, raddr2));
      check("cmp_hi", hi_o, rst ? 32'h0 : (wb_hi_we ? wb_hi : m_hi));
      check("cmp_lo", lo_o, rst ? 32'h0 : (wb_lo_we ? wb_lo : m_lo));
`ifdef WB_REGFILE_TRACE_EN
      check("cmp_wr_cnt", dbg_gpr_wr_cnt, m_cnt);
      check("cmp_last_inst", dbg_last_inst, m_last);
`endif
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with every input trying to produce a nonzero output
    rst = 1'b1;
    wb_reg_we = 1'b1; wb_waddr = 5'd5; wb_data = 32'hCAFE0001;
    wb_hi_we = 1'b1; wb_hi = 32'h7; wb_lo_we = 1'b1; wb_lo = 32'h8;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
`ifdef WB_REGFILE_TRACE_EN
    wb_inst = 32'h0;
`endif
    #3;
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_rdata2", rdata2, 32'h0);
    check("rst_hi", hi_o, 32'h0);
    check("rst_lo", lo_o, 32'h0);
    tick; tick;
    rst = 1'b0;
    wb_reg_we = 1'b0; wb_hi_we = 1'b0; wb_lo_we = 1'b0;
    re2 = 1'b0;
    run_cmp = 1'b1;

    // Populate $3, then pulse reset between edges
    wb_reg_we = 1'b1; wb_waddr = 5'd3; wb_data = 32'h11; raddr1 = 5'd3;
    #1 check("byp_r3", rdata1, 32'h11);
    tick;
    wb_reg_we = 1'b0; wb_hi_we = 1'b1; wb_hi = 32'h77;
    #1 check("stored_r3", rdata1, 32'h11);
    #5 rst = 1'b1;
    #1 check("async_rst_rdata1", rdata1, 32'h0);
    check("async_rst_hi", hi_o, 32'h0);
    #1 rst = 1'b0; wb_hi_we = 1'b0;
    #1 check("r3_cleared", rdata1, 32'h0);
    tick;

    // Every register reads zero after reset
    re1 = 1'b1; re2 = 1'b1;
    for (int i = 1; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(32 - i);
      #1 check("post_rst_r1", rdata1, 32'h0);
      check("post_rst_r2", rdata2, 32'h0);
      tick;
    end
    re2 = 1'b0;

    // Write $5, read back, then disable the port
    wb_reg_we = 1'b1; wb_waddr = 5'd5; wb_data = 32'hDEADBEEF;
`ifdef WB_REGFILE_TRACE_EN
    wb_inst = 32'h00A52820;
`endif
    raddr1 = 5'd1;
    tick;
    wb_reg_we = 1'b0; re1 = 1'b1; raddr1 = 5'd5;
    #1 check("read_r5", rdata1, 32'hDEADBEEF);
    tick;
    re1 = 1'b0;
    #1 check("re1_off", rdata1, 32'h0);
    tick;

    // Same-cycle bypass on both ports
    wb_reg_we = 1'b1; wb_waddr = 5'd7; wb_data = 32'h1234;
    re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
    #1 check("byp_p1", rdata1, 32'h1234);
    check("byp_p2", rdata2, 32'h1234);
    tick;
    wb_reg_we = 1'b0;
    #1 check("stored_r7", rdata1, 32'h1234);
    tick;

    // $0 ignores writes
    wb_reg_we = 1'b1; wb_waddr = 5'd0; wb_data = 32'hFFFFFFFF; raddr1 = 5'd0;
    #1 check("r0_same", rdata1, 32'h0);
    tick;
    wb_reg_we = 1'b0;
    #1 check("r0_after", rdata1, 32'h0);
    tick;

    // HI only, then LO only, then both
    wb_hi_we = 1'b1; wb_hi = 32'hA5A5A5A5; wb_lo = 32'hFFFF;
    #1 check("hi_byp", hi_o, 32'hA5A5A5A5);
    check("lo_unch", lo_o, 32'h0);
    tick;
    wb_hi_we = 1'b0; wb_lo_we = 1'b1; wb_lo = 32'h3;
    #1 check("hi_hold", hi_o, 32'hA5A5A5A5);
    check("lo_byp", lo_o, 32'h3);
    tick;
    wb_lo_we = 1'b0;
    #1 check("lo_stored", lo_o, 32'h3);
    tick;
    wb_hi_we = 1'b1; wb_hi = 32'h1; wb_lo_we = 1'b1; wb_lo = 32'h2;
    tick;
    wb_hi_we = 1'b0; wb_lo_we = 1'b0;
    #1 check("hi_both", hi_o, 32'h1);
    check("lo_both", lo_o, 32'h2);

    // Edge addresses on the two ports independently
    wb_reg_we = 1'b1; wb_waddr = 5'd31; wb_data = 32'h80000001;
    tick;
    wb_waddr = 5'd1; wb_data = 32'h5A5A0F0F;
    raddr1 = 5'd31; raddr2 = 5'd1;
    #1 check("r31", rdata1, 32'h80000001);
    check("r1_byp", rdata2, 32'h5A5A0F0F);
    tick;
    wb_reg_we = 1'b0;
    tick;

    // Reset during a write wins
    wb_reg_we = 1'b1; wb_waddr = 5'd9; wb_data = 32'h55; rst = 1'b1;
    tick;
    rst = 1'b0; wb_reg_we = 1'b0; raddr1 = 5'd9;
    #1 check("r9_after_rst", rdata1, 32'h0);
`ifdef WB_REGFILE_TRACE_EN
    check("trace_cnt_rst", dbg_gpr_wr_cnt, 32'h0);
`endif
    tick;
    tick;

    run_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
